// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the 16-bit memory bus between the 6502 core and one DMA requester,
// with bounded DMA bursts and a forced core cooldown. Optional macro ARB_STATS_EN adds a stolen-cycle counter.
module bus_arbiter #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CPU_MIN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic        cpu_read_write,
  input  logic [7:0]  cpu_data_write,
  output logic        cpu_ena,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic        dma_read_write,
  input  logic [7:0]  dma_data_write,
  input  logic        dma_last,
  output logic        dma_grant,
  output logic        dma_ack,
  output logic [15:0] mem_address,
  output logic        mem_read_write,
  output logic [7:0]  mem_data_write
`ifdef ARB_STATS_EN
  ,
  input  logic        stats_clr,
  output logic [15:0] stolen_cycles
`endif
);

  typedef enum logic [1:0] {
    OWN_CPU    = 2'd0,
    DMA_ACTIVE = 2'd1,
    COOLDOWN   = 2'd2
  } state_t;

  localparam logic [7:0] BEAT_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] COOL_LAST = 8'(CPU_MIN - 1);

  state_t      state_r;
  logic [7:0]  beat_cnt_r;
  logic [7:0]  cool_cnt_r;
  logic        grant_s;

  // Bus ownership FSM with burst and cooldown counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= OWN_CPU;
      beat_cnt_r <= 8'd0;
      cool_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        OWN_CPU: begin
          // Core write cycles are never stolen
          if (dma_req && cpu_read_write) begin
            state_r    <= DMA_ACTIVE;
            beat_cnt_r <= 8'd0;
          end
        end
        DMA_ACTIVE: begin
          if (!dma_req) begin
            state_r <= OWN_CPU;
          end else begin
            if (beat_cnt_r != 8'hFF) begin
              beat_cnt_r <= beat_cnt_r + 8'd1;
            end
            if (dma_last) begin
              state_r <= OWN_CPU;
            end else if (beat_cnt_r == BEAT_LAST) begin
              state_r    <= COOLDOWN;
              cool_cnt_r <= 8'd0;
            end
          end
        end
        COOLDOWN: begin
          if (cool_cnt_r != 8'hFF) begin
            cool_cnt_r <= cool_cnt_r + 8'd1;
          end
          if (cool_cnt_r == COOL_LAST) begin
            state_r <= OWN_CPU;
          end
        end
        default: begin
          state_r    <= OWN_CPU;
          beat_cnt_r <= 8'd0;
          cool_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign grant_s = (state_r == DMA_ACTIVE);

  // Ownership decode and memory-port mux
  always_comb begin
    dma_grant = grant_s;
    cpu_ena   = !grant_s;
    dma_ack   = grant_s & dma_req;
    if (grant_s) begin
      mem_address    = dma_address;
      mem_read_write = dma_read_write;
      mem_data_write = dma_data_write;
    end else begin
      mem_address    = cpu_address;
      mem_read_write = cpu_read_write;
      mem_data_write = cpu_data_write;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stolen_cnt_r;

  // Saturating count of frozen core cycles; clear beats increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stolen_cnt_r <= 16'd0;
    end else if (stats_clr) begin
      stolen_cnt_r <= 16'd0;
    end else if (grant_s && (stolen_cnt_r != 16'hFFFF)) begin
      stolen_cnt_r <= stolen_cnt_r + 16'd1;
    end
  end

  assign stolen_cycles = stolen_cnt_r;
`endif

endmodule
